bcd_to_binary_seq: RTL and testbench
====================================

Name: bcd_to_binary_seq

Overview:
Multi-cycle, parametrised BCD-to-binary converter with valid/ready handshakes on both sides.
Converts DIGITS packed BCD digits plus a separate sign flag into an OUT_W-bit result, one digit per cycle, most-significant digit first (acc = acc*10 + digit).
Flags invalid digits and magnitude overflow.
Sits between the BCD keypad/display datapath and the binary ALU, replacing the single-cycle fixed 7-digit converter.

Parameters:
DIGITS, 7, number of BCD digits in in_bcd (>=1)
OUT_W, 32, output width; the magnitude occupies OUT_W-1 bits, the MSB is the sign

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand present
in_ready  output  1  converter can accept an operand
in_bcd  input  4*DIGITS  packed BCD; digit i = in_bcd[4i+3:4i]; digit 0 is the least significant
in_sign  input  1  1 = negative
out_valid  output  1  result present
out_ready  input  1  consumer accepts the result
out_bin  output  OUT_W  converted result
out_err  output  2  bit0 = invalid digit (>9); bit1 = magnitude overflow

Behaviour:
- Reset (async, rst_n=0): state=IDLE, in_ready=1, out_valid=0, out_bin=0, out_err=0, accumulator=0, digit counter=0.
- FSM states:
  - IDLE: in_ready=1. When in_valid&in_ready, capture in_bcd and in_sign, clear the accumulator and error flags, set cnt=DIGITS-1, go to CONV.
  - CONV: in_ready=0. Each cycle: acc <= acc*10 + digit[cnt]. If digit[cnt]>9, set the sticky err0. When cnt==0 go to DONE; otherwise cnt <= cnt-1.
  - DONE: out_valid=1. out_bin and out_err are registered and stable. When out_ready=1, go to IDLE. out_valid stays high until that transfer.
- Latency: operand accepted at edge T; out_valid high after edge T+DIGITS. Minimum accept-to-accept interval is DIGITS+2 cycles.
- out_ready is ignored outside DONE. in_valid is ignored outside IDLE; a new operand is never accepted in the DONE→IDLE handoff cycle.
- Accumulator width: ceil(log2(10^DIGITS)) bits plus 1 guard bit, so there is no internal wrap.
- Overflow: err1 is set if the final magnitude > 2^(OUT_W-1)-1.
- Result formation in DONE (sign-magnitude default):
  - Any err bit set: out_bin = 0.
  - Otherwise: out_bin = {in_sign & (mag!=0), mag[OUT_W-2:0]}.
  - Negative zero is normalised to +0.
- Both error bits may be set together.
- out_bin and out_err are updated only on entry to DONE and hold their value in IDLE until the next result.
- Reset mid-conversion: the operation is abandoned and nothing is emitted.

Optional Feature:
BCD2BIN_TWOS_COMP_EN
- Defined: the non-error result is two's complement, out_bin = in_sign ? -mag : mag, over OUT_W bits. Overflow limit for negative inputs becomes mag > 2^(OUT_W-1), so -2^(OUT_W-1) is legal.
- Undefined: sign-magnitude as above.
- Latency, handshakes and error reporting are identical in both builds.

Test Plan:
- Positive value: DIGITS=7, in_bcd=0x1234567, sign=0 → out_bin=0x0012D687, out_err=00, out_valid 7 cycles after accept.
- Negative value: in_bcd=0x1234567, sign=1 → out_bin=0x8012D687 in the default build; 0xFFED2979 with BCD2BIN_TWOS_COMP_EN.
- Maximum and negative zero: in_bcd=0x9999999, sign=0 → 0x0098967F. in_bcd=0x0000000, sign=1 → 0x00000000, err=00.
- Invalid digit: in_bcd=0x00000A3 → out_bin=0, out_err=01.
- Overflow: DIGITS=4, OUT_W=8, in_bcd=0x0200 → out_bin=0x00, out_err=10. With the two's-complement macro, 0x0128 sign=1 → 0x80, err=00.
- Backpressure and reset:
  - Hold out_ready=0 for 5 cycles in DONE → out_valid, out_bin and out_err stable; in_ready=0; in_valid pulses ignored.
  - Assert rst_n=0 at CONV cycle 3 → next cycle in_ready=1, out_valid=0, out_bin=0; no result emitted.

Source files
------------

// File: rtl/bcd_to_binary_seq_if.sv
// Valid/ready operand and result channels of the sequential BCD-to-binary converter.
interface bcd_to_binary_seq_if #(
  parameter int unsigned DIGITS = 7,
  parameter int unsigned OUT_W  = 32
);
  logic                  in_valid;
  logic                  in_ready;
  logic [4*DIGITS-1:0]   in_bcd;
  logic                  in_sign;
  logic                  out_valid;
  logic                  out_ready;
  logic [OUT_W-1:0]      out_bin;
  logic [1:0]            out_err;

  modport master (
    output in_valid, in_bcd, in_sign, out_ready,
    input  in_ready, out_valid, out_bin, out_err
  );

  modport slave (
    input  in_valid, in_bcd, in_sign, out_ready,
    output in_ready, out_valid, out_bin, out_err
  );
endinterface

// File: rtl/bcd_to_binary_seq.sv
// Multi-cycle BCD-to-binary converter, one digit per cycle, MSD first.
// Optional build macro BCD2BIN_TWOS_COMP_EN selects a two's-complement result instead of sign-magnitude.
module bcd_to_binary_seq #(
  parameter int unsigned DIGITS = 7,
  parameter int unsigned OUT_W  = 32
) (
  input logic                clk,
  input logic                rst_n,
  bcd_to_binary_seq_if.slave bus
);

  localparam int unsigned BCD_W = 4 * DIGITS;
  // floor(DIGITS*log2(10)) + 1 bits hold 10^DIGITS - 1; one more is the guard bit
  localparam int unsigned ACC_W = (DIGITS * 3321928) / 1000000 + 2;
  localparam int unsigned CMP_W = ((ACC_W > OUT_W) ? ACC_W : OUT_W) + 1;
  localparam int unsigned CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state;
  logic [BCD_W-1:0]   bcd_q;
  logic               sign_q;
  logic [ACC_W-1:0]   acc;
  logic [CNT_W-1:0]   cnt;
  logic               err_dig;

  logic [3:0]         digit_c;
  logic               dig_bad_c;
  logic [ACC_W-1:0]   acc_nxt_c;
  logic [CMP_W-1:0]   mag_c;
  logic [CMP_W-1:0]   lim_c;
  logic [OUT_W-1:0]   mag_trunc_c;
  logic [1:0]         err_c;
  logic [OUT_W-1:0]   res_c;

  // Digit step, overflow test and final result, valid on the last CONV cycle
  always_comb begin
    digit_c     = bcd_q[BCD_W-1 -: 4];
    dig_bad_c   = (digit_c > 4'd9);
    acc_nxt_c   = (acc << 3) + (acc << 1) + ACC_W'(digit_c);
    mag_c       = CMP_W'(acc_nxt_c);
    mag_trunc_c = mag_c[OUT_W-1:0];
`ifdef BCD2BIN_TWOS_COMP_EN
    lim_c = sign_q ? (CMP_W'(1) << (OUT_W - 1))
                   : ((CMP_W'(1) << (OUT_W - 1)) - CMP_W'(1));
    res_c = sign_q ? (~mag_trunc_c + OUT_W'(1)) : mag_trunc_c;
`else
    lim_c = (CMP_W'(1) << (OUT_W - 1)) - CMP_W'(1);
    res_c = {sign_q & (mag_c != '0), mag_c[OUT_W-2:0]};
`endif
    err_c = {(mag_c > lim_c), err_dig | dig_bad_c};
    if (err_c != 2'b00) begin
      res_c = '0;
    end
  end

  // Control FSM with registered handshake and result outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      bus.in_ready  <= 1'b1;
      bus.out_valid <= 1'b0;
      bus.out_bin   <= '0;
      bus.out_err   <= 2'b00;
      acc           <= '0;
      cnt           <= '0;
      bcd_q         <= '0;
      sign_q        <= 1'b0;
      err_dig       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.in_valid && bus.in_ready) begin
            bcd_q        <= bus.in_bcd;
            sign_q       <= bus.in_sign;
            acc          <= '0;
            err_dig      <= 1'b0;
            cnt          <= CNT_W'(DIGITS - 1);
            bus.in_ready <= 1'b0;
            state        <= S_CONV;
          end
        end
        S_CONV: begin
          acc     <= acc_nxt_c;
          err_dig <= err_dig | dig_bad_c;
          bcd_q   <= bcd_q << 4;
          if (cnt == '0) begin
            bus.out_valid <= 1'b1;
            bus.out_bin   <= res_c;
            bus.out_err   <= err_c;
            state         <= S_DONE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        S_DONE: begin
          // in_ready rises with the exit edge, so the handoff cycle never accepts
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            bus.in_ready  <= 1'b1;
            state         <= S_IDLE;
          end
        end
        default: begin
          bus.out_valid <= 1'b0;
          bus.in_ready  <= 1'b1;
          state         <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_to_binary_seq.sv
// Scoreboard bench for bcd_to_binary_seq: a 7-digit/32-bit and a 4-digit/8-bit instance.
module tb_bcd_to_binary_seq;

  localparam int unsigned DA = 7;
  localparam int unsigned WA = 32;
  localparam int unsigned BA = 4 * DA;
  localparam int unsigned DB = 4;
  localparam int unsigned WB = 8;
  localparam int unsigned BB = 4 * DB;

  typedef struct {
    longint unsigned bin;
    logic [1:0]      err;
    int              t_acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_bad = 0;
  bit   rr_en = 1'b0;
  exp_t qa[$];
  exp_t qb[$];
  logic pva = 1'b0;
  logic pvb = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bcd_to_binary_seq_if #(.DIGITS(DA), .OUT_W(WA)) ifa ();
  bcd_to_binary_seq_if #(.DIGITS(DB), .OUT_W(WB)) ifb ();

  bcd_to_binary_seq #(.DIGITS(DA), .OUT_W(WA)) u_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
  bcd_to_binary_seq #(.DIGITS(DB), .OUT_W(WB)) u_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

  // Reference: decimal value of the digits, then range and sign rules on plain integers
  function automatic exp_t model(input longint unsigned bcd, input bit sign, input int nd, input int w);
    longint unsigned mag, lim, mask, d;
    exp_t r;
    mag = 0;
    r.err = 2'b00;
    for (int i = nd - 1; i >= 0; i--) begin
      d = (bcd >> (4 * i)) & 64'd15;
      if (d > 9) r.err[0] = 1'b1;
      mag = mag * 10 + d;
    end
    lim = (64'd1 << (w - 1)) - 1;
`ifdef BCD2BIN_TWOS_COMP_EN
    if (sign) lim = lim + 1;
`endif
    if (mag > lim) r.err[1] = 1'b1;
    mask = (64'd1 << w) - 1;
    if (r.err != 2'b00) r.bin = 0;
`ifdef BCD2BIN_TWOS_COMP_EN
    else r.bin = sign ? ((~mag + 1) & mask) : (mag & mask);
`else
    else r.bin = (sign && mag != 0) ? ((mag | (64'd1 << (w - 1))) & mask) : (mag & mask);
`endif
    r.t_acc = 0;
    return r;
  endfunction

  function automatic longint unsigned rnd_bcd(input int nd);
    longint unsigned v;
    longint unsigned d;
    v = 0;
    for (int i = 0; i < nd; i++) begin
      d = ($urandom_range(0, 15) == 0) ? longint'($urandom_range(10, 15)) : longint'($urandom_range(0, 9));
      v = v | (d << (4 * i));
    end
    return v;
  endfunction

  task automatic chk(input string nm, input longint unsigned act, input longint unsigned exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Present one operand; record its expectation at the acceptance edge when tracked
  task automatic send(input bit inst, input longint unsigned bcd, input bit sign, input bit track);
    exp_t e;
    int   n;
    bit   rdy;
    e = model(bcd, sign, inst ? DB : DA, inst ? WB : WA);
    n = 0;
    @(posedge clk); #1;
    if (inst) begin
      ifb.in_valid = 1'b1; ifb.in_bcd = BB'(bcd); ifb.in_sign = sign;
    end else begin
      ifa.in_valid = 1'b1; ifa.in_bcd = BA'(bcd); ifa.in_sign = sign;
    end
    forever begin
      @(negedge clk);
      rdy = inst ? ifb.in_ready : ifa.in_ready;
      if (rdy) break;
      n++;
      if (n > 200) begin
        n_vec++; n_bad++;
        $display("FAIL accept_timeout: inst %0d in_ready stayed 0, required 1", inst);
        ifa.in_valid = 1'b0; ifb.in_valid = 1'b0;
        return;
      end
    end
    e.t_acc = cyc + 1;
    if (track) begin
      if (inst) qb.push_back(e); else qa.push_back(e);
    end
    @(posedge clk); #1;
    ifa.in_valid = 1'b0;
    ifb.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((qa.size() != 0 || qb.size() != 0) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", longint'(qa.size() + qb.size()), 0);
  endtask

  // Monitors: latency on out_valid rise, payload on each transfer
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      pva <= 1'b0;
    end else begin
      if (ifa.out_valid && !pva && qa.size() != 0)
        chk("a_latency", longint'(cyc - qa[0].t_acc), DA);
      if (ifa.out_valid && ifa.out_ready) begin
        if (qa.size() == 0) begin
          n_vec++; n_bad++;
          $display("FAIL a_spurious: got result %0h with no operand outstanding", ifa.out_bin);
        end else begin
          e = qa.pop_front();
          chk("a_out_bin", 64'(ifa.out_bin), e.bin);
          chk("a_out_err", 64'(ifa.out_err), 64'(e.err));
        end
      end
      pva <= ifa.out_valid;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      pvb <= 1'b0;
    end else begin
      if (ifb.out_valid && !pvb && qb.size() != 0)
        chk("b_latency", longint'(cyc - qb[0].t_acc), DB);
      if (ifb.out_valid && ifb.out_ready) begin
        if (qb.size() == 0) begin
          n_vec++; n_bad++;
          $display("FAIL b_spurious: got result %0h with no operand outstanding", ifb.out_bin);
        end else begin
          e = qb.pop_front();
          chk("b_out_bin", 64'(ifb.out_bin), e.bin);
          chk("b_out_err", 64'(ifb.out_err), 64'(e.err));
        end
      end
      pvb <= ifb.out_valid;
    end
  end

  // Random consumer backpressure
  initial begin
    forever begin
      @(posedge clk); #1;
      if (rr_en) begin
        ifa.out_ready = ($urandom_range(0, 3) != 0);
        ifb.out_ready = ($urandom_range(0, 3) != 0);
      end
    end
  end

  initial begin
    int   n;
    exp_t e;
    ifa.in_valid = 1'b0; ifa.in_bcd = '0; ifa.in_sign = 1'b0; ifa.out_ready = 1'b1;
    ifb.in_valid = 1'b0; ifb.in_bcd = '0; ifb.in_sign = 1'b0; ifb.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_a_in_ready", 64'(ifa.in_ready), 1);
    chk("rst_a_out_valid", 64'(ifa.out_valid), 0);
    chk("rst_a_out_bin", 64'(ifa.out_bin), 0);
    chk("rst_a_out_err", 64'(ifa.out_err), 0);
    chk("rst_b_in_ready", 64'(ifb.in_ready), 1);
    chk("rst_b_out_valid", 64'(ifb.out_valid), 0);
    rst_n = 1'b1;

    // Directed values, wide instance
    send(0, 64'h1234567, 1'b0, 1'b1);
    send(0, 64'h1234567, 1'b1, 1'b1);
    send(0, 64'h9999999, 1'b0, 1'b1);
    send(0, 64'h0000000, 1'b1, 1'b1);
    send(0, 64'h00000A3, 1'b0, 1'b1);
    send(0, 64'h0000001, 1'b1, 1'b1);
    // Overflow boundaries, narrow instance
    send(1, 64'h0200, 1'b0, 1'b1);
    send(1, 64'h0127, 1'b0, 1'b1);
    send(1, 64'h0128, 1'b0, 1'b1);
    send(1, 64'h0127, 1'b1, 1'b1);
    send(1, 64'h0128, 1'b1, 1'b1);
    send(1, 64'h0129, 1'b1, 1'b1);
    send(1, 64'hF999, 1'b1, 1'b1);
    send(1, 64'h0000, 1'b1, 1'b1);
    drain();

    // Backpressure: result must hold, input side must stay closed
    ifa.out_ready = 1'b0;
    send(0, 64'h0004096, 1'b1, 1'b1);
    e = model(64'h0004096, 1'b1, DA, WA);
    n = 0;
    while (!ifa.out_valid && n < 50) begin @(negedge clk); n++; end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      ifa.in_valid = (i % 2 == 0);
      ifa.in_bcd = BA'(rnd_bcd(DA));
      @(negedge clk);
      chk("bp_out_valid", 64'(ifa.out_valid), 1);
      chk("bp_out_bin", 64'(ifa.out_bin), e.bin);
      chk("bp_out_err", 64'(ifa.out_err), 64'(e.err));
      chk("bp_in_ready", 64'(ifa.in_ready), 0);
    end
    @(posedge clk); #1;
    ifa.in_valid = 1'b0;
    ifa.out_ready = 1'b1;
    drain();
    repeat (DA + 3) @(negedge clk);
    chk("bp_no_extra", 64'(ifa.out_valid), 0);

    // Reset during the third conversion cycle
    send(0, 64'h7654321, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_in_ready", 64'(ifa.in_ready), 1);
    chk("mid_rst_out_valid", 64'(ifa.out_valid), 0);
    chk("mid_rst_out_bin", 64'(ifa.out_bin), 0);
    rst_n = 1'b1;
    repeat (DA + 4) @(negedge clk);
    chk("mid_rst_no_result", 64'(ifa.out_valid), 0);

    // Randomized traffic on both instances with random backpressure
    rr_en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      send(0, rnd_bcd(DA), 1'($urandom_range(0, 1)), 1'b1);
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end
    for (int i = 0; i < 60; i++) begin
      send(1, rnd_bcd(DB), 1'($urandom_range(0, 1)), 1'b1);
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end
    rr_en = 1'b0;
    @(posedge clk); #1;
    ifa.out_ready = 1'b1;
    ifb.out_ready = 1'b1;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
